// File: rtl/toast_sequencer_if.sv
// Timer/heater load handshake between the toast sequencer (master) and the timer block (slave).
interface toast_sequencer_if;
  logic        t_write;
  logic        t_write_ack;
  logic [9:0]  t_time;
  logic [7:0]  t_dc;
  logic        t_start;
  logic        t_stop;
  logic [11:0] t_led;

  modport master (
    output t_write, t_time, t_dc, t_start, t_stop,
    input  t_write_ack, t_led
  );

  modport slave (
    input  t_write, t_time, t_dc, t_start, t_stop,
    output t_write_ack, t_led
  );
endinterface

// File: rtl/toast_sequencer.sv
// Toast-cycle controller: lever press -> timer load -> timed heat run -> eject pulse -> cool-down,
// with cancel, lever-release, ack-timeout and run-watchdog handling. All outputs registered.
module toast_sequencer #(
  parameter int unsigned BASE_TIME    = 60,
  parameter int unsigned STEP_TIME    = 15,
  parameter int unsigned BASE_DC      = 80,
  parameter int unsigned STEP_DC      = 15,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned MAX_RUN      = 32'd2_000_000_000,
  parameter int unsigned EJECT_CYCLES = 50_000,
  parameter int unsigned COOL_CYCLES  = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lever_down,
  input  logic                     cancel,
  input  logic [2:0]               shade,
  toast_sequencer_if.master        tmr,
  output logic                     eject,
  output logic                     busy,
  output logic                     fault,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RUN      = 3'd3,
    S_CLEAR    = 3'd4,
    S_EJECT    = 3'd5,
    S_COOL     = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  localparam logic [31:0] ACK_LAST   = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] RUN_LAST   = 32'(MAX_RUN - 1);
  localparam logic [31:0] EJECT_LAST = 32'(EJECT_CYCLES - 1);
  localparam logic [31:0] COOL_LAST  = 32'(COOL_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic        r_lever_rel;
  logic        r_write;
  logic [9:0]  r_time;
  logic [7:0]  r_dc;
  logic        r_start;
  logic        r_stop;
  logic        r_eject;
  logic        r_busy;
  logic        r_fault;

  logic        w_press;
  logic        w_abort;
  logic [31:0] w_time_raw;
  logic [31:0] w_dc_raw;
  logic [9:0]  w_time_sat;
  logic [7:0]  w_dc_sat;

  // r_lever_rel holds "lever was up last cycle"; clearing it on reset means a lever
  // held through reset, or held when COOL ends, never looks like a fresh press.
  assign w_press = lever_down & r_lever_rel & ~cancel;
  assign w_abort = cancel | ~lever_down;

  always_comb begin
    w_time_raw = BASE_TIME + 32'(shade) * STEP_TIME;
    w_dc_raw   = BASE_DC + 32'(shade) * STEP_DC;
    w_time_sat = (w_time_raw > 32'd599) ? 10'd599 : w_time_raw[9:0];
    w_dc_sat   = (w_dc_raw > 32'd200) ? 8'd200 : w_dc_raw[7:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_press) w_next = S_LOAD;
      S_LOAD:     w_next = (r_time == '0) ? S_EJECT : S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (tmr.t_write_ack)      w_next = S_RUN;
        else if (r_cnt == ACK_LAST) w_next = S_FAULT;
        else if (w_abort)         w_next = S_CLEAR;
      end
      S_RUN: begin
        // First RUN cycle (r_cnt==0) ignores a stale zero display from the timer.
        if (w_abort)                              w_next = S_CLEAR;
        else if (r_cnt != '0 && tmr.t_led == '0)  w_next = S_EJECT;
        else if (r_cnt == RUN_LAST)               w_next = S_FAULT;
      end
      S_CLEAR:    w_next = S_EJECT;
      S_EJECT:    if (r_cnt == EJECT_LAST) w_next = S_COOL;
      S_COOL:     if (r_cnt == COOL_LAST) w_next = S_IDLE;
      S_FAULT:    if (cancel && !lever_down) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    if (w_next != r_state)  w_cnt_nxt = '0;
    else if (r_cnt == '1)   w_cnt_nxt = r_cnt;
    else                    w_cnt_nxt = r_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_lever_rel <= 1'b0;
      r_write     <= 1'b0;
      r_time      <= '0;
      r_dc        <= '0;
      r_start     <= 1'b0;
      r_stop      <= 1'b1;
      r_eject     <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_nxt;
      r_lever_rel <= ~lever_down;
      r_write     <= (w_next == S_LOAD) || (w_next == S_CLEAR);
      if (w_next == S_LOAD) begin
        r_time <= w_time_sat;
        r_dc   <= w_dc_sat;
      end else if (w_next == S_CLEAR) begin
        r_time <= '0;
        r_dc   <= '0;
      end
      r_start     <= (w_next == S_RUN);
      r_stop      <= (w_next != S_RUN);
      r_eject     <= (w_next == S_EJECT);
      r_busy      <= (w_next != S_IDLE);
      r_fault     <= (w_next == S_FAULT);
    end
  end

  assign tmr.t_write = r_write;
  assign tmr.t_time  = r_time;
  assign tmr.t_dc    = r_dc;
  assign tmr.t_start = r_start;
  assign tmr.t_stop  = r_stop;
  assign eject       = r_eject;
  assign busy        = r_busy;
  assign fault       = r_fault;
  assign state       = r_state;

endmodule

// File: tb/tb_toast_sequencer.sv
// Self-checking bench for toast_sequencer: vector table, hand-written corner sequences,
// then randomized stimulus against a cycle-level behavioural model.
module tb_toast_sequencer;

  localparam int unsigned EJ = 5;
  localparam int unsigned CL = 7;
  localparam int unsigned MR = 40;
  localparam int unsigned AT = 16;

  logic clk;
  logic reset, lever, cancel;
  logic [2:0] shade;
  logic eject, busy, fault;
  logic [2:0] state;

  logic reset2, lever2, cancel2;
  logic [2:0] shade2;
  logic eject2, busy2, fault2;
  logic [2:0] state2;

  toast_sequencer_if tif();
  toast_sequencer_if tif2();

  toast_sequencer #(
    .ACK_TIMEOUT (AT),
    .MAX_RUN     (MR),
    .EJECT_CYCLES(EJ),
    .COOL_CYCLES (CL)
  ) dut (
    .clk(clk), .reset(reset), .lever_down(lever), .cancel(cancel), .shade(shade),
    .tmr(tif), .eject(eject), .busy(busy), .fault(fault), .state(state)
  );

  toast_sequencer #(
    .BASE_TIME   (550),
    .BASE_DC     (180),
    .ACK_TIMEOUT (AT),
    .MAX_RUN     (MR),
    .EJECT_CYCLES(EJ),
    .COOL_CYCLES (CL)
  ) dut_sat (
    .clk(clk), .reset(reset2), .lever_down(lever2), .cancel(cancel2), .shade(shade2),
    .tmr(tif2), .eject(eject2), .busy(busy2), .fault(fault2), .state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          lv;
    bit          cn;
    int          sh;
    bit          ack;
    logic [11:0] led;
    int          rep;
    int          st;
    bit          wr;
    int          tm;
    int          dc;
    bit          stt;
    bit          ej;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit lv, input bit cn, input int sh, input bit ack, input logic [11:0] led,
                     input int rep, input int st, input bit wr, input int tm, input int dc,
                     input bit stt, input bit ej);
    vec_t v;
    v = '{lv, cn, sh, ack, led, rep, st, wr, tm, dc, stt, ej};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input bit wr, input int tm, input int dc,
                           input bit stt, input bit ej);
    n_vec++;
    chk({tag, ".state"},   32'(state),        32'(st));
    chk({tag, ".t_write"}, 32'(tif.t_write),  32'(wr));
    chk({tag, ".t_time"},  32'(tif.t_time),   32'(tm));
    chk({tag, ".t_dc"},    32'(tif.t_dc),     32'(dc));
    chk({tag, ".t_start"}, 32'(tif.t_start),  32'(stt));
    chk({tag, ".t_stop"},  32'(tif.t_stop),   32'(!stt));
    chk({tag, ".eject"},   32'(eject),        32'(ej));
    chk({tag, ".busy"},    32'(busy),         32'(st != 0));
    chk({tag, ".fault"},   32'(fault),        32'(st == 7));
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Behavioural model: phase number, cycles already spent in it, last lever level.
  int m_ph, m_age, m_time, m_dc;
  bit m_prev;

  task automatic model_step(input bit r, input bit L, input bit C, input logic [2:0] S,
                            input bit A, input logic [11:0] led);
    int nph;
    if (r) begin
      m_ph = 0; m_age = 0; m_prev = 1'b1; m_time = 0; m_dc = 0;
      return;
    end
    nph = m_ph;
    case (m_ph)
      0: if (L && !m_prev && !C) nph = 1;
      1: nph = (m_time == 0) ? 5 : 2;
      2: if (A) nph = 3; else if (m_age + 1 == AT) nph = 7; else if (C || !L) nph = 4;
      3: if (C || !L) nph = 4; else if (m_age > 0 && led == 0) nph = 5; else if (m_age + 1 == MR) nph = 7;
      4: nph = 5;
      5: if (m_age + 1 == EJ) nph = 6;
      6: if (m_age + 1 == CL) nph = 0;
      default: if (C && !L) nph = 0;
    endcase
    if (nph == 1) begin
      m_time = sat(60 + 15 * int'(S), 599);
      m_dc   = sat(80 + 15 * int'(S), 200);
    end
    if (nph == 4) begin
      m_time = 0;
      m_dc   = 0;
    end
    m_age  = (nph == m_ph) ? m_age + 1 : 0;
    m_ph   = nph;
    m_prev = L;
  endtask

  task automatic press_to_run(input int s);
    lever = 1'b1; shade = 3'(s);
    clk1();
    clk1();
    tif.t_write_ack = 1'b1;
    clk1();
    tif.t_write_ack = 1'b0;
    check_all("h_run", 3, 0, sat(60 + 15 * s, 599), sat(80 + 15 * s, 200), 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "time limit");
  end

  initial begin
    int shades[3];
    reset = 1'b1; lever = 1'b0; cancel = 1'b0; shade = '0;
    tif.t_write_ack = 1'b0; tif.t_led = 12'h130;
    reset2 = 1'b1; lever2 = 1'b0; cancel2 = 1'b0; shade2 = '0;
    tif2.t_write_ack = 1'b0; tif2.t_led = 12'h130;

    clk1();
    clk1();
    check_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Normal cycle, shade 2: load, ack, first-cycle led ignore, eject, cool, held lever
    add(0,0,2,0,12'h130,1, 0,0, 0,  0,0,0);
    add(1,0,2,0,12'h130,1, 1,1,90,110,0,0);
    add(1,0,2,0,12'h130,1, 2,0,90,110,0,0);
    add(1,0,2,1,12'h130,1, 3,0,90,110,1,0);
    add(1,0,2,0,12'h000,1, 3,0,90,110,1,0);
    add(1,0,2,0,12'h000,1, 5,0,90,110,0,1);
    add(1,1,2,0,12'h000,4, 5,0,90,110,0,1);
    add(1,0,2,0,12'h130,1, 6,0,90,110,0,0);
    add(0,0,2,0,12'h130,2, 6,0,90,110,0,0);
    add(1,0,2,0,12'h130,4, 6,0,90,110,0,0);
    add(1,0,2,0,12'h130,1, 0,0,90,110,0,0);
    add(1,0,2,0,12'h130,3, 0,0,90,110,0,0);
    // Cancel during RUN with t_led==0 in the same cycle -> CLEAR
    add(0,0,0,0,12'h130,1, 0,0,90,110,0,0);
    add(1,0,0,0,12'h130,1, 1,1,60, 80,0,0);
    add(1,0,0,0,12'h130,1, 2,0,60, 80,0,0);
    add(1,0,0,1,12'h130,1, 3,0,60, 80,1,0);
    add(1,0,0,0,12'h130,1, 3,0,60, 80,1,0);
    add(1,1,0,0,12'h000,1, 4,1, 0,  0,0,0);
    add(1,0,0,0,12'h130,1, 5,0, 0,  0,0,1);
    add(1,0,0,0,12'h130,4, 5,0, 0,  0,0,1);
    add(1,0,0,0,12'h130,7, 6,0, 0,  0,0,0);
    add(1,0,0,0,12'h130,1, 0,0, 0,  0,0,0);
    add(0,0,0,0,12'h130,1, 0,0, 0,  0,0,0);
    // Ack timeout -> FAULT, exit only on cancel with lever up
    add(1,0,1,0,12'h130,1, 1,1,75, 95,0,0);
    add(1,0,1,0,12'h130,16,2,0,75, 95,0,0);
    add(1,0,1,0,12'h130,1, 7,0,75, 95,0,0);
    add(1,1,1,0,12'h130,1, 7,0,75, 95,0,0);
    add(0,0,1,0,12'h130,1, 7,0,75, 95,0,0);
    add(0,1,1,0,12'h130,1, 0,0,75, 95,0,0);
    add(0,0,1,0,12'h130,1, 0,0,75, 95,0,0);
    // Lever released while waiting for ack -> CLEAR
    add(1,0,3,0,12'h130,1, 1,1,105,125,0,0);
    add(1,0,3,0,12'h130,1, 2,0,105,125,0,0);
    add(0,0,3,0,12'h130,1, 4,1, 0,  0,0,0);
    add(0,0,3,0,12'h130,5, 5,0, 0,  0,0,1);
    add(0,0,3,0,12'h130,7, 6,0, 0,  0,0,0);
    add(0,0,3,0,12'h130,1, 0,0, 0,  0,0,0);
    // Run watchdog: display never reaches zero -> FAULT after MAX_RUN cycles
    add(1,0,5,0,12'h130,1, 1,1,135,155,0,0);
    add(1,0,5,0,12'h130,1, 2,0,135,155,0,0);
    add(1,0,5,1,12'h130,1, 3,0,135,155,1,0);
    add(1,0,5,0,12'h130,39,3,0,135,155,1,0);
    add(1,0,5,0,12'h130,1, 7,0,135,155,0,0);
    add(0,1,5,0,12'h130,1, 0,0,135,155,0,0);

    foreach (tbl[i]) begin
      lever = tbl[i].lv; cancel = tbl[i].cn; shade = 3'(tbl[i].sh);
      tif.t_write_ack = tbl[i].ack; tif.t_led = tbl[i].led;
      for (int r = 0; r < tbl[i].rep; r++) begin
        clk1();
        check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].wr, tbl[i].tm, tbl[i].dc,
                  tbl[i].stt, tbl[i].ej);
      end
    end
    cancel = 1'b0; tif.t_write_ack = 1'b0; tif.t_led = 12'h130;

    // Reset in the middle of RUN, lever kept down through and after reset
    lever = 1'b0;
    clk1();
    press_to_run(2);
    repeat (3) clk1();
    reset = 1'b1;
    #1;
    check_all("rst_in_run", 0, 0, 0, 0, 0, 0);
    clk1();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clk1();
      check_all("held_after_rst_run", 0, 0, 0, 0, 0, 0);
    end

    // Reset in the middle of EJECT
    lever = 1'b0;
    clk1();
    press_to_run(4);
    clk1();
    tif.t_led = 12'h000;
    clk1();
    check_all("eject_entry", 5, 0, 120, 140, 0, 1);
    clk1();
    reset = 1'b1;
    #1;
    check_all("rst_in_eject", 0, 0, 0, 0, 0, 0);
    clk1();
    reset = 1'b0;
    tif.t_led = 12'h130;
    for (int k = 0; k < 4; k++) begin
      clk1();
      check_all("held_after_rst_eject", 0, 0, 0, 0, 0, 0);
    end

    // Saturation of loaded time and duty
    shades = '{0, 3, 7};
    foreach (shades[j]) begin
      reset2 = 1'b1; lever2 = 1'b0;
      clk1();
      reset2 = 1'b0;
      clk1();
      lever2 = 1'b1; shade2 = 3'(shades[j]);
      clk1();
      n_vec++;
      chk($sformatf("sat%0d.state", j),   32'(state2),       32'd1);
      chk($sformatf("sat%0d.t_write", j), 32'(tif2.t_write), 32'd1);
      chk($sformatf("sat%0d.t_time", j),  32'(tif2.t_time),  32'(sat(550 + 15 * shades[j], 599)));
      chk($sformatf("sat%0d.t_dc", j),    32'(tif2.t_dc),    32'(sat(180 + 15 * shades[j], 200)));
    end

    // Randomized run against the model
    reset = 1'b1; lever = 1'b0; cancel = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 12'h130);
    clk1();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) lever = ~lever;
      cancel = ($urandom_range(0, 29) == 0);
      shade = 3'($urandom_range(0, 7));
      tif.t_write_ack = ($urandom_range(0, 9) < 4);
      tif.t_led = ($urandom_range(0, 9) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      @(posedge clk);
      model_step(reset, lever, cancel, shade, tif.t_write_ack, tif.t_led);
      #1;
      check_all($sformatf("rnd%0d", k), m_ph, (m_ph == 1) || (m_ph == 4), m_time, m_dc,
                m_ph == 3, m_ph == 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
